// File: rtl/corefifo_fwft_prefetch.sv
// FWFT read-side prefetch stage: hides RAM read latency behind a small buffer and a registered dout.
// Optional sticky underflow flag is built only when FWFT_UNDERFLOW_EN is defined.
module corefifo_fwft_prefetch #(
    parameter int unsigned RWIDTH    = 18,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned PF_DEPTH  = 2,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned READ_LOW  = 0
) (
    input  logic                              pos_rclk,
    input  logic                              aresetn_rclk,
    input  logic                              sresetn_rclk,
    input  logic                              rd_en,
    input  logic                              fifo_empty,
    input  logic                              fifo_aempty,
    input  logic [RWIDTH-1:0]                 fifo_dout,
    output logic                              fifo_rd_en,
    output logic [RWIDTH-1:0]                 dout,
    output logic                              fwft_dvld,
    output logic                              empty,
    output logic                              aempty,
    output logic [$clog2(PF_DEPTH+2)-1:0]     level,
    output logic                              underflow
);

    localparam int unsigned LW  = $clog2(PF_DEPTH + 2);
    localparam int unsigned PW  = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(PF_DEPTH + RD_LAT + 2);
    localparam int unsigned CAP = PF_DEPTH + 1;

    logic [RD_LAT-1:0] inflight_sr;
    logic [RD_LAT-1:0] inflight_sr_next;
    logic [CW-1:0]     inflight_cnt;
    logic [CW-1:0]     committed;

    logic [RWIDTH-1:0] pf_mem [PF_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [LW-1:0]     buf_cnt;
    logic [LW-1:0]     buf_cnt_next;
    logic [LW-1:0]     level_next;

    logic              re_p;
    logic              pop;
    logic              arrival;
    logic              load_slot;
    logic              buf_rd;
    logic              bypass;
    logic              buf_wr;
    logic              load;
    logic              dvld_next;
    logic              aempty_next;
    logic [RWIDTH-1:0] dout_next;

    // Pointer advance with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(PF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request tracker: stage 0 takes the new request, last stage marks an arriving word.
    always_comb begin
        inflight_sr_next    = '0;
        inflight_sr_next[0] = fifo_rd_en;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            inflight_sr_next[i] = inflight_sr[i-1];
        end
        inflight_cnt = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight_sr[i]);
        end
    end

    assign arrival = inflight_sr[RD_LAT-1];
    assign re_p    = (READ_LOW != 0) ? ~rd_en : rd_en;
    assign pop     = re_p & fwft_dvld;

    // Credit: never request more than the buffer plus dout can absorb.
    assign committed  = inflight_cnt + CW'(buf_cnt) + CW'(fwft_dvld) - CW'(pop);
    assign fifo_rd_en = aresetn_rclk & sresetn_rclk & ~fifo_empty & (committed < CW'(CAP));

    // Dout load: buffered words first, arriving word bypasses only an empty buffer.
    always_comb begin
        load_slot    = ~fwft_dvld | pop;
        buf_rd       = load_slot & (buf_cnt != '0);
        bypass       = load_slot & (buf_cnt == '0) & arrival;
        buf_wr       = arrival & ~bypass;
        load         = buf_rd | bypass;
        dout_next    = buf_rd ? pf_mem[head] : fifo_dout;
        dvld_next    = load | (fwft_dvld & ~pop);
        buf_cnt_next = buf_cnt + LW'(buf_wr) - LW'(buf_rd);
        level_next   = buf_cnt_next + LW'(dvld_next);
        aempty_next  = fifo_aempty | (32'(level_next) <= AE_THRESH);
    end

    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            inflight_sr <= '0;
            head        <= '0;
            tail        <= '0;
            buf_cnt     <= '0;
            dout        <= '0;
            fwft_dvld   <= 1'b0;
            level       <= '0;
            aempty      <= 1'b1;
        end else if (!sresetn_rclk) begin
            inflight_sr <= '0;
            head        <= '0;
            tail        <= '0;
            buf_cnt     <= '0;
            dout        <= '0;
            fwft_dvld   <= 1'b0;
            level       <= '0;
            aempty      <= 1'b1;
        end else begin
            inflight_sr <= inflight_sr_next;
            if (buf_rd) head <= ptr_inc(head);
            if (buf_wr) tail <= ptr_inc(tail);
            buf_cnt     <= buf_cnt_next;
            if (load) dout <= dout_next;
            fwft_dvld   <= dvld_next;
            level       <= level_next;
            aempty      <= aempty_next;
        end
    end

    // Buffer storage carries no reset; pointers and count define its contents.
    always_ff @(posedge pos_rclk) begin
        if (buf_wr && sresetn_rclk) begin
            pf_mem[tail] <= fifo_dout;
        end
    end

    assign empty = ~fwft_dvld;

`ifdef FWFT_UNDERFLOW_EN
    logic underflow_q;

    // Sticky: any read attempt while nothing is presented.
    always_ff @(posedge pos_rclk or negedge aresetn_rclk) begin
        if (!aresetn_rclk) begin
            underflow_q <= 1'b0;
        end else if (!sresetn_rclk) begin
            underflow_q <= 1'b0;
        end else if (re_p && !fwft_dvld) begin
            underflow_q <= 1'b1;
        end
    end

    assign underflow = underflow_q;
`else
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_corefifo_fwft_prefetch.sv
// Directed vector table plus hand-written sequences for corefifo_fwft_prefetch (RD_LAT=3, PF_DEPTH=4).
module tb_corefifo_fwft_prefetch;

    localparam int unsigned RW  = 18;
    localparam int unsigned LAT = 3;
    localparam int unsigned DEP = 4;
    localparam int unsigned AE  = 1;
    localparam int unsigned LW  = $clog2(DEP + 2);
`ifdef FWFT_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif

    logic          pos_rclk = 1'b0;
    logic          aresetn_rclk;
    logic          sresetn_rclk;
    logic          rd_en;
    logic          fifo_empty;
    logic          fifo_aempty;
    logic [RW-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [RW-1:0] dout;
    logic          fwft_dvld;
    logic          empty;
    logic          aempty;
    logic [LW-1:0] level;
    logic          underflow;

    corefifo_fwft_prefetch #(
        .RWIDTH(RW), .RD_LAT(LAT), .PF_DEPTH(DEP), .AE_THRESH(AE), .READ_LOW(0)
    ) dut (
        .pos_rclk(pos_rclk), .aresetn_rclk(aresetn_rclk), .sresetn_rclk(sresetn_rclk),
        .rd_en(rd_en), .fifo_empty(fifo_empty), .fifo_aempty(fifo_aempty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .dout(dout),
        .fwft_dvld(fwft_dvld), .empty(empty), .aempty(aempty), .level(level),
        .underflow(underflow)
    );

    always #5 pos_rclk = ~pos_rclk;

    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] ctl_q[$];
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] dl[LAT];
    bit            hold_empty = 1'b0;
    bit            req_seen;
    bit            popped;

    typedef struct {
        bit            rd;
        int unsigned   wr;
        bit            fae;
        bit            exp_req;
        bit            exp_dvld;
        logic [RW-1:0] exp_dout;
        int unsigned   exp_lvl;
        bit            exp_ae;
        bit            exp_uf;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = hold_empty || (ctl_q.size() == 0);
    endtask

    task automatic push(input logic [RW-1:0] w);
        ctl_q.push_back(w);
        exp_q.push_back(w);
        upd_empty();
    endtask

    task automatic flush_model();
        ctl_q.delete();
        exp_q.delete();
        for (int k = 0; k < int'(LAT); k++) dl[k] = '0;
        fifo_dout = '0;
        upd_empty();
    endtask

    // One clock: sample and score before the edge, then advance the controller/RAM model.
    task automatic tick();
        logic [RW-1:0] e;
        @(negedge pos_rclk);
        req_seen = fifo_rd_en;
        popped   = rd_en && fwft_dvld;
        if (popped) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got %0h expected none", dout);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", 32'(dout), 32'(e));
            end
        end
        checks++;
        if (32'(level) > DEP + 1) begin
            errors++;
            $display("FAIL level_bound: got %0d expected <= %0d", level, DEP + 1);
        end
        @(posedge pos_rclk);
        #1;
        for (int k = int'(LAT) - 1; k > 0; k--) dl[k] = dl[k-1];
        if (req_seen) begin
            if (ctl_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL overread: got request expected none");
                dl[0] = '0;
            end else begin
                dl[0] = ctl_q.pop_front();
            end
        end else begin
            dl[0] = '0;
        end
        fifo_dout = dl[LAT-1];
        upd_empty();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] nxt;
        int first, last, npop, pushed, budget;

        nxt = RW'('h11);
        aresetn_rclk = 1'b0; sresetn_rclk = 1'b1;
        rd_en = 1'b0; fifo_aempty = 1'b0;
        flush_model();

        //            rd wr fae req dvld dout    lvl ae uf
        tbl[0] = '{1'b0, 2, 1'b0, 1'b1, 1'b0, RW'('h00), 0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 0, 1'b0, 1'b1, 1'b0, RW'('h00), 0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, RW'('h00), 0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, RW'('h11), 1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 0, 1'b1, 1'b0, 1'b1, RW'('h11), 2, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 0, 1'b0, 1'b0, 1'b1, RW'('h11), 2, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 0, 1'b0, 1'b0, 1'b1, RW'('h22), 1, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, RW'('h22), 0, 1'b1, 1'b0};
        tbl[8] = '{1'b1, 0, 1'b0, 1'b0, 1'b0, RW'('h22), 0, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 0, 1'b0, 1'b0, 1'b0, RW'('h22), 0, 1'b1, 1'b1};

        // Reset state
        tick(); tick();
        check("rst_dvld",   32'(fwft_dvld),  32'd0);
        check("rst_empty",  32'(empty),      32'd1);
        check("rst_aempty", 32'(aempty),     32'd1);
        check("rst_level",  32'(level),      32'd0);
        check("rst_dout",   32'(dout),       32'd0);
        check("rst_uf",     32'(underflow),  32'd0);
        push(RW'('h3ff));
        #1;
        check("rst_rden",   32'(fifo_rd_en), 32'd0);
        flush_model();
        aresetn_rclk = 1'b1;

        // Vector table: first-word latency, buffering, aempty, pop-to-empty, underflow
        for (int i = 0; i < NV; i++) begin
            rd_en = tbl[i].rd;
            fifo_aempty = tbl[i].fae;
            for (int w = 0; w < int'(tbl[i].wr); w++) begin
                push(nxt);
                nxt = nxt + RW'('h11);
            end
            tick();
            check($sformatf("v%0d_req", i),   32'(req_seen),  32'(tbl[i].exp_req));
            check($sformatf("v%0d_dvld", i),  32'(fwft_dvld), 32'(tbl[i].exp_dvld));
            check($sformatf("v%0d_empty", i), 32'(empty),     32'(!tbl[i].exp_dvld));
            check($sformatf("v%0d_dout", i),  32'(dout),      32'(tbl[i].exp_dout));
            check($sformatf("v%0d_level", i), 32'(level),     tbl[i].exp_lvl);
            check($sformatf("v%0d_ae", i),    32'(aempty),    32'(tbl[i].exp_ae));
            check($sformatf("v%0d_uf", i),    32'(underflow), 32'(UF_EN & tbl[i].exp_uf));
        end
        fifo_aempty = 1'b0;

        // Fill with no reads: requests stop at DEP+1 local words, none lost
        rd_en = 1'b0;
        for (int i = 0; i < 20; i++) push(RW'('h100 + i));
        for (int i = 0; i < 12; i++) tick();
        check("fill_level", 32'(level),        DEP + 1);
        check("fill_req",   32'(req_seen),     32'd0);
        check("fill_ctlq",  32'(ctl_q.size()), 32'd15);
        check("fill_ae",    32'(aempty),       32'd0);

        // Async reset mid-stream
        rd_en = 1'b1;
        tick(); tick();
        aresetn_rclk = 1'b0;
        #1;
        check("arst_rden_now", 32'(fifo_rd_en), 32'd0);
        rd_en = 1'b0;
        flush_model();
        tick();
        check("arst_dvld",  32'(fwft_dvld), 32'd0);
        check("arst_level", 32'(level),     32'd0);
        check("arst_empty", 32'(empty),     32'd1);
        check("arst_ae",    32'(aempty),    32'd1);
        check("arst_uf",    32'(underflow), 32'd0);
        aresetn_rclk = 1'b1;
        tick();

        // Streaming: 100 words with rd_en held, one pop per cycle once started
        for (int i = 0; i < 100; i++) push(RW'('h1000 + i));
        rd_en = 1'b1;
        first = -1; last = -1; npop = 0;
        for (int c = 0; c < 400 && npop < 100; c++) begin
            tick();
            if (popped) begin
                if (first < 0) first = c;
                last = c;
                npop++;
            end
        end
        check("stream_pops", 32'(npop),             32'd100);
        check("stream_span", 32'(last - first + 1), 32'd100);

        // Sync reset with words held; no request while it is asserted
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) push(RW'('h2000 + i));
        for (int i = 0; i < 10; i++) tick();
        check("srst_pre_level", 32'(level), DEP + 1);
        sresetn_rclk = 1'b0;
        flush_model();
        push(RW'('h2abc));
        #1;
        check("srst_rden", 32'(fifo_rd_en), 32'd0);
        tick();
        check("srst_dvld",  32'(fwft_dvld), 32'd0);
        check("srst_level", 32'(level),     32'd0);
        check("srst_req",   32'(req_seen),  32'd0);
        sresetn_rclk = 1'b1;

        // Random rd_en and controller stalls; scoreboard checks order inside tick
        pushed = 0; budget = 0;
        while ((pushed < 10000 || exp_q.size() != 0) && budget < 60000) begin
            rd_en = 1'($urandom_range(0, 1));
            hold_empty = ($urandom_range(0, 3) == 0);
            if (pushed < 10000 && ctl_q.size() < 6) begin
                push(RW'($urandom));
                pushed++;
            end
            upd_empty();
            tick();
            budget++;
        end
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_pushed",  32'(pushed),       32'd10000);
        hold_empty = 1'b0;
        rd_en = 1'b0;
        upd_empty();
        tick();
        check("end_dvld", 32'(fwft_dvld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
